// File: rtl/instr_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_responder_if
// Description : Fetch request/response bus between the IF-stage PC circuit
//               (master) and the instruction memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_responder_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    // Initiator side: drives the PC request and consumes responses
    modport master (
        output req_valid,
        output req_addr,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    // Responder side: accepts requests and returns instruction words
    modport slave (
        input  req_valid,
        input  req_addr,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_responder
// Description : Instruction-fetch responder. Accepts PC-driven word fetches
//               over a valid/ready bus, inserts programmable wait states and
//               returns the stored word (or an out-of-range error). A
//               boot-load port writes the program image at any time.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_responder #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_mem_responder_if.slave  bus,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  busy
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    // Counter preset so that WAIT lasts exactly WAIT_STATES cycles
    localparam logic [3:0] c_cnt_init = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [31:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    logic                  w_accept;
    logic [31:0]           w_fetch_addr;
    logic                  w_out_of_range;

    // Loads take priority over new fetches but never stall one in flight
    assign bus.req_ready = (r_state == c_idle) & ~ld_en & ~rst;
    assign w_accept      = bus.req_valid & bus.req_ready;

    // With zero wait states RESP is entered on the accept edge itself, so the
    // live request address must be used before it has been captured.
    assign w_fetch_addr   = (r_state == c_idle) ? bus.req_addr : r_addr;
    assign w_out_of_range = |(w_fetch_addr >> ADDR_WIDTH);

    assign bus.rsp_valid = (r_state == c_resp);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign busy          = (r_state != c_idle);

    // Boot-load write port; the fetch read below sees the pre-write value
    // when both happen on the same edge (read-before-write).
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Fetch FSM: accept, count wait states, register and hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_cnt      <= 4'd0;
            r_addr     <= 32'd0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_addr <= bus.req_addr;
                        if (WAIT_STATES == 0) begin
                            r_state    <= c_resp;
                            r_rsp_err  <= w_out_of_range;
                            r_rsp_data <= w_out_of_range ? '0 : mem[w_fetch_addr[ADDR_WIDTH-1:0]];
                        end else begin
                            r_state <= c_wait;
                            r_cnt   <= c_cnt_init;
                        end
                    end
                end
                c_wait: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= c_resp;
                        r_rsp_err  <= w_out_of_range;
                        r_rsp_data <= w_out_of_range ? '0 : mem[w_fetch_addr[ADDR_WIDTH-1:0]];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_resp: begin
                    if (bus.rsp_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
